// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: default geometry and the
// per-edge operation state that drives the request handshakes.
package fifo_pkg;

   localparam int FIFO_WIDTH = 32;
   localparam int FIFO_DEPTH = 8;
   localparam int FIFO_AW    = 3;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WRITE    = 3'd1,
      READ     = 3'd2,
      RDWR     = 3'd3,
      WR_ERR   = 3'd4,
      RD_ERR   = 3'd5,
      WR_RDERR = 3'd6,
      RD_WRERR = 3'd7
   } op_state_t;

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x WIDTH storage of resettable D-register words; write on clk, read combinational.
// Latency: written data readable after the writing edge. No backpressure: writes are unconditional when we=1.
module fifo_regfile
   import fifo_pkg::*;
#(
   parameter int WIDTH = FIFO_WIDTH,
   parameter int DEPTH = FIFO_DEPTH,
   parameter int AW    = FIFO_AW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Each word is its own cleared register so reset leaves no stale data behind.
   for (genvar g = 0; g < DEPTH; g++) begin : g_word
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            mem[g] <= '0;
         end else if (we && (waddr == AW'(g))) begin
            mem[g] <= wdata;
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// 8-entry in-order FIFO with count/flags and per-request ack/error pulses.
// Latency: dout valid one cycle after accepted read; rejected requests (full/empty) flag an error, never stall.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int WIDTH = FIFO_WIDTH,
   parameter int DEPTH = FIFO_DEPTH,
   parameter int AW    = FIFO_AW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [AW:0]      data_count,
   output logic             full,
   output logic             empty,
   output logic             wr_ack,
   output logic             wr_err,
   output logic             rd_ack,
   output logic             rd_err
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   op_state_t        state_q, state_d;
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [WIDTH-1:0] rdata;
   logic             do_wr, do_rd;
   logic             has_data, has_room;

   assign has_data = (data_count != '0);
   assign has_room = (data_count != FULL_CNT);

   always_comb begin
      state_d = IDLE;
      case ({wr_en, rd_en})
         2'b10:   state_d = has_room ? WRITE : WR_ERR;
         2'b01:   state_d = has_data ? READ : RD_ERR;
         2'b11: begin
            // Empty and full are mutually exclusive for DEPTH >= 2.
            if (!has_data)      state_d = WR_RDERR;
            else if (!has_room) state_d = RD_WRERR;
            else                state_d = RDWR;
         end
         default: state_d = IDLE;
      endcase
   end

   assign do_wr = (state_d == WRITE) || (state_d == RDWR) || (state_d == WR_RDERR);
   assign do_rd = (state_d == READ)  || (state_d == RDWR) || (state_d == RD_WRERR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         data_count <= '0;
         dout       <= '0;
      end else begin
         state_q <= state_d;
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
            dout   <= rdata;
         end
         case ({do_wr, do_rd})
            2'b10:   data_count <= data_count + 1'b1;
            2'b01:   data_count <= data_count - 1'b1;
            default: data_count <= data_count;
         endcase
      end
   end

   fifo_regfile #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_regfile (
      .clk   (clk),
      .reset (reset),
      .we    (do_wr),
      .waddr (wr_ptr),
      .wdata (din),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   assign full   = (data_count == FULL_CNT);
   assign empty  = (data_count == '0);
   assign wr_ack = (state_q == WRITE)  || (state_q == RDWR)   || (state_q == WR_RDERR);
   assign rd_ack = (state_q == READ)   || (state_q == RDWR)   || (state_q == RD_WRERR);
   assign wr_err = (state_q == WR_ERR) || (state_q == RD_WRERR);
   assign rd_err = (state_q == RD_ERR) || (state_q == WR_RDERR);

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo.
module tb_sync_fifo;

   localparam int WIDTH = 32;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             wr_en, rd_en;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic [AW:0]      data_count;
   logic             full, empty, wr_ack, wr_err, rd_ack, rd_err;

   int tests_run = 0;
   int tests_failed = 0;

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .din        (din),
      .dout       (dout),
      .data_count (data_count),
      .full       (full),
      .empty      (empty),
      .wr_ack     (wr_ack),
      .wr_err     (wr_err),
      .rd_ack     (rd_ack),
      .rd_err     (rd_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one request on the next edge, then settle just past it for checking.
   task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d);
      @(negedge clk);
      wr_en = w;
      rd_en = r;
      din   = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_hs(input string tag, input logic wa, input logic we, input logic ra, input logic re);
      chk({tag, ".wr_ack"}, 32'(wr_ack), 32'(wa));
      chk({tag, ".wr_err"}, 32'(wr_err), 32'(we));
      chk({tag, ".rd_ack"}, 32'(rd_ack), 32'(ra));
      chk({tag, ".rd_err"}, 32'(rd_err), 32'(re));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      din   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // 1. Reset state after two idle cycles
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      chk("rst.empty", 32'(empty), 32'd1);
      chk("rst.full", 32'(full), 32'd0);
      chk("rst.count", 32'(data_count), 32'd0);
      chk("rst.dout", dout, 32'd0);
      chk_hs("rst", 1'b0, 1'b0, 1'b0, 1'b0);

      // 2. Fill, then overflow
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 1'b0, 32'(i));
         chk("fill.wr_ack", 32'(wr_ack), 32'd1);
         chk("fill.count", 32'(data_count), 32'(i));
         chk("fill.full", 32'(full), 32'(i == 8));
      end
      step(1'b1, 1'b0, 32'h9);
      chk_hs("ovf", 1'b0, 1'b1, 1'b0, 1'b0);
      chk("ovf.count", 32'(data_count), 32'd8);
      chk("ovf.full", 32'(full), 32'd1);

      // 3. Drain in order, then underflow
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 1'b1, '0);
         chk("drain.rd_ack", 32'(rd_ack), 32'd1);
         chk("drain.dout", dout, 32'(i));
         chk("drain.count", 32'(data_count), 32'(8 - i));
      end
      step(1'b0, 1'b1, '0);
      chk_hs("unf", 1'b0, 1'b0, 1'b0, 1'b1);
      chk("unf.dout", dout, 32'h8);
      chk("unf.empty", 32'(empty), 32'd1);

      // 4a. Simultaneous at count 0: write only, no bypass to dout
      step(1'b1, 1'b1, 32'h30);
      chk_hs("both0", 1'b1, 1'b0, 1'b0, 1'b1);
      chk("both0.count", 32'(data_count), 32'd1);
      chk("both0.dout", dout, 32'h8);
      step(1'b1, 1'b0, 32'h31);
      step(1'b1, 1'b0, 32'h32);
      chk("pre3.count", 32'(data_count), 32'd3);

      // 4b. Simultaneous at count 3
      step(1'b1, 1'b1, 32'h33);
      chk_hs("both3", 1'b1, 1'b0, 1'b1, 1'b0);
      chk("both3.count", 32'(data_count), 32'd3);
      chk("both3.dout", dout, 32'h30);

      // 4c. Simultaneous at count 8
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'(32'h34 + i));
      chk("pre8.full", 32'(full), 32'd1);
      step(1'b1, 1'b1, 32'h39);
      chk_hs("both8", 1'b0, 1'b1, 1'b1, 1'b0);
      chk("both8.count", 32'(data_count), 32'd7);
      chk("both8.dout", dout, 32'h31);
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b1, '0);
         chk("both8.drain", dout, 32'(32'h32 + i));
      end
      chk("both8.empty", 32'(empty), 32'd1);

      // 5. Pointer wrap across two passes
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'(32'h50 + i));
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, '0);
         chk("wrap1.dout", dout, 32'(32'h50 + i));
      end
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, 32'(32'hA0 + i));
         chk("wrap.wr_err", 32'(wr_err), 32'd0);
      end
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, '0);
         chk("wrap2.dout", dout, 32'(32'hA0 + i));
         chk("wrap2.rd_err", 32'(rd_err), 32'd0);
      end
      chk("wrap.empty", 32'(empty), 32'd1);

      // 6. Asynchronous reset between edges with count 5
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'(32'hC0 + i));
      chk("mid.count", 32'(data_count), 32'd5);
      @(negedge clk);
      #2;
      reset = 1'b1;
      wr_en = 1'b0;
      #1;
      chk("arst.count", 32'(data_count), 32'd0);
      chk("arst.empty", 32'(empty), 32'd1);
      chk("arst.dout", dout, 32'd0);
      chk_hs("arst", 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      reset = 1'b0;
      step(1'b0, 1'b1, '0);
      chk_hs("post", 1'b0, 1'b0, 1'b0, 1'b1);
      chk("post.count", 32'(data_count), 32'd0);
      chk("post.dout", dout, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
